// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared sizes and helpers for the reg_bank4 register bank.
//   NUM_REGS  number of registers in the bank
//   SEL_W     width of the one-hot write select
//   ADDR_W    width of the binary read addresses
//   CNT_W     width of the committed-write counter
//   is_onehot true when exactly one select bit is set
package reg_bank_pkg;

   localparam int NUM_REGS = 4;
   localparam int SEL_W    = 4;
   localparam int ADDR_W   = 2;
   localparam int CNT_W    = 8;

   function automatic logic is_onehot(input logic [3:0] v);
      // Clearing the lowest set bit leaves zero only for a single set bit.
      return (v != '0) && ((v & (v - 4'd1)) == '0);
   endfunction

endpackage

// File: rtl/reg_bank4_onehot_check.sv
// onehot_check: combinational decode of the one-hot write select.
//   wr_sel  in   SEL_W   one-hot write select
//   legal   out  1       wr_sel has exactly one bit set
//   idx     out  ADDR_W  binary index of the set bit (meaningful only when legal)
module onehot_check
   import reg_bank_pkg::*;
(
   input  logic [SEL_W-1:0]  wr_sel,
   output logic              legal,
   output logic [ADDR_W-1:0] idx
);

   always_comb begin
      legal = is_onehot(wr_sel);
      idx   = '0;
      for (int unsigned i = 0; i < SEL_W; i++) begin
         if (wr_sel[i]) idx = ADDR_W'(i);
      end
   end

endmodule

// File: rtl/reg_bank4.sv
// reg_bank4: 4-entry register bank with one-hot write select and two
// registered binary-addressed read ports.
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_data  write request, one-hot target, data
//   rd_en                 read request for both ports
//   rd_addr_a/rd_addr_b   binary read addresses
//   rd_data_a/rd_data_b   registered read data (1-cycle latency)
//   rd_valid              high the cycle after an accepted read
//   sel_err/err_clr       sticky illegal-select flag and its synchronous clear
//   wr_count              committed write count, wraps modulo 256
// Build option: REG_BANK_BYPASS_EN selects write-first behaviour when a read
// and a legal write hit the same register in one cycle; otherwise read-first.
module reg_bank4
   import reg_bank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              rd_valid,
   output logic              sel_err,
   input  logic              err_clr,
   output logic [CNT_W-1:0]  wr_count
);

   logic [WIDTH-1:0]  regs [NUM_REGS];
   logic              sel_legal;
   logic [ADDR_W-1:0] wr_idx;
   logic              wr_commit;
   logic [WIDTH-1:0]  rd_next_a;
   logic [WIDTH-1:0]  rd_next_b;

   onehot_check u_onehot_check (
      .wr_sel (wr_sel),
      .legal  (sel_legal),
      .idx    (wr_idx)
   );

   assign wr_commit = wr_en && sel_legal;

   always_comb begin
      rd_next_a = regs[rd_addr_a];
      rd_next_b = regs[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
      // Write-first: forward data of a committed write to a port reading it.
      if (wr_commit && (wr_idx == rd_addr_a)) rd_next_a = wr_data;
      if (wr_commit && (wr_idx == rd_addr_b)) rd_next_b = wr_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
         wr_count <= '0;
      end else if (wr_commit) begin
         regs[wr_idx] <= wr_data;
         wr_count     <= wr_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
         end
      end
   end

   // Set has priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 sel_err <= 1'b0;
      else if (wr_en && !sel_legal) sel_err <= 1'b1;
      else if (err_clr)           sel_err <= 1'b0;
   end

endmodule

// File: tb/tb_reg_bank4.sv
module tb_reg_bank4;
   localparam logic [7:0] RV = 8'hC3;
`ifdef REG_BANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en, rd_en, err_clr;
   logic [3:0] wr_sel;
   logic [7:0] wr_data;
   logic [1:0] rd_addr_a, rd_addr_b;
   logic [7:0] rd_data_a, rd_data_b, wr_count;
   logic       rd_valid, sel_err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] m_reg [4];
   logic [7:0] m_rda, m_rdb, m_cnt;
   logic       m_val, m_err;

   always #5 clk = ~clk;

   reg_bank4 #(.WIDTH(8), .RESET_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
      .sel_err(sel_err), .err_clr(err_clr), .wr_count(wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = RV;
      m_rda = 8'h00; m_rdb = 8'h00; m_cnt = 8'h00; m_val = 1'b0; m_err = 1'b0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".rd_data_a"}, {24'h0, rd_data_a}, {24'h0, m_rda});
      chk({tag, ".rd_data_b"}, {24'h0, rd_data_b}, {24'h0, m_rdb});
      chk({tag, ".rd_valid"},  {31'h0, rd_valid},  {31'h0, m_val});
      chk({tag, ".sel_err"},   {31'h0, sel_err},   {31'h0, m_err});
      chk({tag, ".wr_count"},  {24'h0, wr_count},  {24'h0, m_cnt});
   endtask

   // One clock: model evaluates the spec rules on the pre-edge inputs,
   // then outputs are compared on the following falling edge.
   task automatic tick(input string tag);
      bit legal;
      int k;
      @(posedge clk);
      legal = wr_en && ($countones(wr_sel) == 1);
      k = 0;
      for (int i = 0; i < 4; i++) if (wr_sel[i]) k = i;
      if (rd_en) begin
         m_rda = (BYP && legal && k == int'(rd_addr_a)) ? wr_data : m_reg[rd_addr_a];
         m_rdb = (BYP && legal && k == int'(rd_addr_b)) ? wr_data : m_reg[rd_addr_b];
      end
      m_val = rd_en;
      if (legal) begin
         m_reg[k] = wr_data;
         m_cnt = m_cnt + 8'd1;
      end
      if (wr_en && !legal) m_err = 1'b1;
      else if (err_clr)    m_err = 1'b0;
      @(negedge clk);
      chk_all(tag);
   endtask

   task automatic drive(input logic we, input logic [3:0] sel, input logic [7:0] d,
                        input logic re, input logic [1:0] a, input logic [1:0] b,
                        input logic clr, input string tag);
      wr_en = we; wr_sel = sel; wr_data = d; rd_en = re;
      rd_addr_a = a; rd_addr_b = b; err_clr = clr;
      tick(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      wr_en = 0; wr_sel = 0; wr_data = 0; rd_en = 0;
      rd_addr_a = 0; rd_addr_b = 0; err_clr = 0;
      rst_n = 1'b0;
      #2;
      do_reset();

      // 1: read after reset returns RESET_VAL on both ports
      drive(0, 4'b0000, 8'h00, 1, 2'd0, 2'd3, 0, "t1");
      chk("t1.a_const", {24'h0, rd_data_a}, {24'h0, RV});
      chk("t1.b_const", {24'h0, rd_data_b}, {24'h0, RV});
      chk("t1.valid_const", {31'h0, rd_valid}, 32'd1);

      // 2: write 0x5A to reg2, read it back
      drive(1, 4'b0100, 8'h5A, 0, 2'd0, 2'd0, 0, "t2.wr");
      drive(0, 4'b0000, 8'h00, 1, 2'd2, 2'd1, 0, "t2.rd");
      chk("t2.a_const", {24'h0, rd_data_a}, 32'h5A);
      chk("t2.cnt_const", {24'h0, wr_count}, 32'd1);

      // 3: illegal selects, clear, ignored select when wr_en low
      drive(1, 4'b0110, 8'hEE, 0, 2'd0, 2'd0, 0, "t3.multi");
      drive(1, 4'b0000, 8'hEE, 0, 2'd0, 2'd0, 0, "t3.zero");
      chk("t3.err_const", {31'h0, sel_err}, 32'd1);
      drive(0, 4'b0000, 8'h00, 1, 2'd1, 2'd2, 0, "t3.rd");
      chk("t3.reg2_kept", {24'h0, rd_data_b}, 32'h5A);
      drive(1, 4'b1010, 8'h77, 0, 2'd0, 2'd0, 1, "t3.setwins");
      drive(0, 4'b0000, 8'h00, 0, 2'd0, 2'd0, 1, "t3.clr");
      chk("t3.clr_const", {31'h0, sel_err}, 32'd0);
      drive(0, 4'b1111, 8'h99, 0, 2'd0, 2'd0, 0, "t3.ignored");

      // 4: same-cycle write and read of reg1
      drive(1, 4'b0010, 8'h11, 0, 2'd0, 2'd0, 0, "t4.pre");
      drive(1, 4'b0010, 8'h33, 1, 2'd1, 2'd1, 0, "t4.same");
      chk("t4.same_const", {24'h0, rd_data_a}, BYP ? 32'h33 : 32'h11);
      drive(1, 4'b0011, 8'h44, 1, 2'd1, 2'd0, 0, "t4.illegal_nobyp");
      chk("t4.next_const", {24'h0, rd_data_a}, 32'h33);

      // 5: counter wrap over 256 legal writes from reset
      do_reset();
      for (int i = 0; i < 256; i++)
         drive(1, 4'b0001 << (i % 4), 8'(i), 0, 2'd0, 2'd0, 0, "t5");
      chk("t5.wrap_const", {24'h0, wr_count}, 32'd0);

      // 6: asynchronous reset between edges during a write
      wr_en = 1; wr_sel = 4'b1000; wr_data = 8'hBE; rd_en = 1;
      rd_addr_a = 2'd3; rd_addr_b = 2'd0; err_clr = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("t6.async");
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 4'b0000, 8'h00, 1, 2'd3, 2'd0, 0, "t6.lost");
      chk("t6.lost_const", {24'h0, rd_data_a}, {24'h0, RV});

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), 4'($urandom), 8'($urandom), $urandom_range(0, 1),
               2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
